// File: rtl/amplitude_agc.sv
// Peak-tracking amplitude AGC: measures the peak |x| over a window of valid samples and
// steps the gain word toward a target band. Define AMP_AGC_FREEZE_EN to add a freeze input.
module amplitude_agc #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned WINDOW_LOG2 = 10,
    parameter int unsigned TOL         = 256,
    parameter int unsigned AMP_INIT    = 16384
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         enable,
    input  logic        [DATA_WIDTH-1:0] target,
    input  logic        [DATA_WIDTH-1:0] step,
    input  logic signed [DATA_WIDTH-1:0] data_i_tdata,
    input  logic                         data_i_tvalid,
`ifdef AMP_AGC_FREEZE_EN
    input  logic                         freeze,
`endif
    output logic signed [DATA_WIDTH-1:0] amplitude,
    output logic        [DATA_WIDTH-1:0] peak_tdata,
    output logic                         peak_tvalid,
    output logic                         locked
);

    localparam int unsigned W    = DATA_WIDTH;
    localparam int unsigned CntW = (WINDOW_LOG2 > 0) ? WINDOW_LOG2 : 1;

    localparam logic [W-1:0]    MagMax  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]    MinNeg  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W:0]      MagMaxX = {2'b00, {(W-1){1'b1}}};
    localparam logic [W:0]      TolX    = (W+1)'(TOL);
    localparam logic [CntW-1:0] CntLast = {CntW{1'b1}};

    typedef enum logic [1:0] {StIdle, StMeasure, StUpdate} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [W-1:0]       peak_q, peak_d;
    logic [W-1:0]       peak_tdata_q, peak_tdata_d;
    logic               peak_tvalid_q, peak_tvalid_d;
    logic signed [W-1:0] amp_q, amp_d;
    logic               locked_q, locked_d;

    logic [W-1:0] mag, peak_max, amp_inc, amp_dec;
    logic [W:0]   band_hi, band_lo, peak_x, amp_sum, amp_diff;
    logic         upd_en;

    // The most negative sample has no positive twin, so it saturates.
    always_comb begin
        if (!data_i_tdata[W-1]) begin
            mag = data_i_tdata;
        end else if (data_i_tdata == MinNeg) begin
            mag = MagMax;
        end else begin
            mag = -data_i_tdata;
        end
        peak_max = (mag > peak_q) ? mag : peak_q;
    end

    always_comb begin
        peak_x   = {1'b0, peak_tdata_q};
        band_hi  = {1'b0, target} + TolX;
        band_lo  = ({1'b0, target} >= TolX) ? ({1'b0, target} - TolX) : '0;
        amp_sum  = {1'b0, amp_q} + {1'b0, step};
        amp_diff = {1'b0, amp_q} - {1'b0, step};
        amp_inc  = (amp_sum > MagMaxX) ? MagMax : amp_sum[W-1:0];
        amp_dec  = amp_diff[W] ? '0 : amp_diff[W-1:0];
`ifdef AMP_AGC_FREEZE_EN
        upd_en   = !freeze;
`else
        upd_en   = 1'b1;
`endif
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        peak_d        = peak_q;
        peak_tdata_d  = peak_tdata_q;
        peak_tvalid_d = 1'b0;
        amp_d         = amp_q;
        locked_d      = locked_q;
        unique case (state_q)
            StIdle: begin
                cnt_d  = '0;
                peak_d = '0;
                if (enable) state_d = StMeasure;
            end
            StMeasure: begin
                if (!enable) begin
                    cnt_d   = '0;
                    peak_d  = '0;
                    state_d = StIdle;
                end else if (data_i_tvalid) begin
                    if (cnt_q == CntLast) begin
                        peak_tdata_d  = peak_max;
                        peak_tvalid_d = 1'b1;
                        cnt_d         = '0;
                        peak_d        = '0;
                        state_d       = StUpdate;
                    end else begin
                        cnt_d  = cnt_q + 1'b1;
                        peak_d = peak_max;
                    end
                end
            end
            StUpdate: begin
                if (upd_en) begin
                    if (peak_x > band_hi) begin
                        amp_d    = amp_dec;
                        locked_d = 1'b0;
                    end else if (peak_x < band_lo) begin
                        amp_d    = amp_inc;
                        locked_d = 1'b0;
                    end else begin
                        locked_d = 1'b1;
                    end
                end
                cnt_d  = '0;
                peak_d = '0;
                // A sample arriving now opens the next window.
                if (enable) begin
                    state_d = StMeasure;
                    if (data_i_tvalid) begin
                        cnt_d  = CntW'(1);
                        peak_d = mag;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            peak_q        <= '0;
            peak_tdata_q  <= '0;
            peak_tvalid_q <= 1'b0;
            amp_q         <= W'(AMP_INIT);
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            peak_q        <= peak_d;
            peak_tdata_q  <= peak_tdata_d;
            peak_tvalid_q <= peak_tvalid_d;
            amp_q         <= amp_d;
            locked_q      <= locked_d;
        end
    end

    assign amplitude   = amp_q;
    assign peak_tdata  = peak_tdata_q;
    assign peak_tvalid = peak_tvalid_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_amplitude_agc.sv
// Scoreboard bench for amplitude_agc: directed scenarios followed by random traffic,
// checked against a window-level reference model.
module tb_amplitude_agc;

    localparam int WL    = 2;
    localparam int WIN   = 4;
    localparam int TOLV  = 256;
    localparam int AINIT = 16384;
    localparam int AMAX  = 32767;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic               enable = 1'b0;
    logic               data_i_tvalid = 1'b0;
    logic        [15:0] target = '0;
    logic        [15:0] step = '0;
    logic signed [15:0] data_i_tdata = '0;
    logic signed [15:0] amplitude;
    logic        [15:0] peak_tdata;
    logic               peak_tvalid;
    logic               locked;
`ifdef AMP_AGC_FREEZE_EN
    logic               freeze = 1'b0;
`endif

    amplitude_agc #(
        .DATA_WIDTH (16),
        .WINDOW_LOG2(WL),
        .TOL        (TOLV),
        .AMP_INIT   (AINIT)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .enable       (enable),
        .target       (target),
        .step         (step),
        .data_i_tdata (data_i_tdata),
        .data_i_tvalid(data_i_tvalid),
`ifdef AMP_AGC_FREEZE_EN
        .freeze       (freeze),
`endif
        .amplitude    (amplitude),
        .peak_tdata   (peak_tdata),
        .peak_tvalid  (peak_tvalid),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int peak_exp_q[$];
    int amp_exp_q[$];
    int lock_exp_q[$];
    bit amp_pending = 1'b0;

    // Reference model: window contents as a list of magnitudes.
    int m_mode = 0;  // 0 idle, 1 collecting, 2 adjusting
    int m_win[$];
    int m_amp = AINIT;
    int m_lock = 0;
    int m_pk = 0;
    int tgt_n = 0;
    int stp_n = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int mag(input int x);
        if (x == -32768) return AMAX;
        return (x < 0) ? -x : x;
    endfunction

    task automatic apply_update();
        int t, s, lo, hi;
        t  = int'(target);
        s  = int'(step);
        hi = t + TOLV;
        lo = (t - TOLV < 0) ? 0 : t - TOLV;
`ifdef AMP_AGC_FREEZE_EN
        if (!freeze) begin
`endif
        if (m_pk > hi) begin
            m_amp  = (m_amp - s < 0) ? 0 : m_amp - s;
            m_lock = 0;
        end else if (m_pk < lo) begin
            m_amp  = (m_amp + s > AMAX) ? AMAX : m_amp + s;
            m_lock = 0;
        end else begin
            m_lock = 1;
        end
`ifdef AMP_AGC_FREEZE_EN
        end
`endif
        amp_exp_q.push_back(m_amp);
        lock_exp_q.push_back(m_lock);
    endtask

    task automatic model_step();
        if (!resetn) begin
            m_mode = 0;
            m_win.delete();
            m_amp  = AINIT;
            m_lock = 0;
            return;
        end
        case (m_mode)
            0: if (enable) m_mode = 1;
            1: begin
                if (!enable) begin
                    m_win.delete();
                    m_mode = 0;
                end else if (data_i_tvalid) begin
                    m_win.push_back(mag(int'(data_i_tdata)));
                    if (m_win.size() == WIN) begin
                        m_pk = 0;
                        foreach (m_win[i]) if (m_win[i] > m_pk) m_pk = m_win[i];
                        peak_exp_q.push_back(m_pk);
                        m_win.delete();
                        m_mode = 2;
                    end
                end
            end
            default: begin
                apply_update();
                m_win.delete();
                if (enable) begin
                    m_mode = 1;
                    if (data_i_tvalid) m_win.push_back(mag(int'(data_i_tdata)));
                end else begin
                    m_mode = 0;
                end
            end
        endcase
    endtask

    task automatic drive(input bit en, input bit v, input int d, input bit rn);
        @(posedge clk);
        #1;
        resetn        = rn;
        enable        = en;
        data_i_tvalid = v;
        data_i_tdata  = 16'(d);
        target        = 16'(tgt_n);
        step          = 16'(stp_n);
        model_step();
    endtask

    task automatic window(input int a, input int b, input int c, input int d, input int gap);
        int s[4];
        s = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, s[i], 1);
            for (int g = 0; g < gap; g++) drive(1, 0, 0, 1);
        end
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) drive(enable, 0, 0, 1);
        @(negedge clk);
    endtask

    // Monitor: pops expectations whenever the DUT presents a peak, then checks the gain after.
    always @(negedge clk) begin
        if (amp_pending) begin
            amp_pending = 1'b0;
            if (amp_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL amp_update: got update, expected none queued");
            end else begin
                chk("amplitude", int'(amplitude), amp_exp_q.pop_front());
                chk("locked", int'(locked), lock_exp_q.pop_front());
            end
        end
        if (peak_tvalid) begin
            if (peak_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL peak_tvalid: got pulse (peak %0d), expected none", peak_tdata);
            end else begin
                chk("peak_tdata", int'(peak_tdata), peak_exp_q.pop_front());
            end
            amp_pending = 1'b1;
        end
    end

    initial begin
        bit did_rst;
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("rst_amplitude", int'(amplitude), AINIT);
        chk("rst_locked", int'(locked), 0);
        chk("rst_peak_tdata", int'(peak_tdata), 0);
        chk("rst_peak_tvalid", int'(peak_tvalid), 0);

        // Oversized peak pulls the gain down by one step.
        tgt_n = 1000;
        stp_n = 1024;
        drive(1, 0, 0, 1);
        window(100, -3000, 2000, 500, 0);
        settle(3);
        chk("dir_down_amp", int'(amplitude), 15360);
        chk("dir_down_lock", int'(locked), 0);

        // In-band peak with gapped valids locks without moving the gain.
        stp_n = 100;
        window(1100, -50, 20, 300, 2);
        settle(3);
        chk("dir_band_amp", int'(amplitude), 15360);
        chk("dir_band_lock", int'(locked), 1);

        // Abort after two samples, then a full fresh window.
        drive(1, 1, 5, 1);
        drive(1, 1, 6, 1);
        drive(0, 0, 0, 1);
        drive(1, 0, 0, 1);
        window(7, 8, 9, 10, 0);
        settle(3);
        chk("dir_abort_amp", int'(amplitude), 15460);

        // Reset mid-window discards the partial window.
        drive(1, 1, 3000, 1);
        drive(1, 1, 3000, 1);
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 1);
        @(negedge clk);
        chk("midrst_amp", int'(amplitude), AINIT);
        chk("midrst_lock", int'(locked), 0);
        chk("midrst_peak", int'(peak_tdata), 0);
        chk("midrst_valid", int'(peak_tvalid), 0);

        // Small signal, high target: gain climbs and saturates.
        tgt_n = 30000;
        stp_n = 8192;
        drive(1, 0, 0, 1);
        for (int w = 0; w < 3; w++) begin
            window(10, 10, 10, 10, 0);
            drive(1, 0, 0, 1);
        end
        settle(3);
        chk("dir_sat_hi_amp", int'(amplitude), AMAX);

        // Full-scale negative input: gain falls to zero and stays there.
        tgt_n = 1000;
        for (int w = 0; w < 6; w++) begin
            window(-32768, -32768, -32768, -32768, 0);
            drive(1, 0, 0, 1);
        end
        settle(3);
        chk("dir_sat_lo_amp", int'(amplitude), 0);

        // Random traffic; target changes rarely, step every cycle.
        did_rst = 1'b0;
        tgt_n = 8000;
        for (int i = 0; i < 3000; i++) begin
            int d;
            bit en, v, rn;
            if ($urandom_range(0, 49) == 0) tgt_n = $urandom_range(0, 20000);
            stp_n = $urandom_range(0, 4096);
            en = ($urandom_range(0, 19) != 0);
            v  = ($urandom_range(0, 9) < 7);
            d  = ($urandom_range(0, 31) == 0) ? -32768 : int'($urandom_range(0, 40000)) - 20000;
            rn = 1'b1;
            if (!did_rst && i > 1500 && m_mode == 1 && m_win.size() >= 2) begin
                rn = 1'b0;
                did_rst = 1'b1;
            end
            drive(en, v, d, rn);
        end
        drive(0, 0, 0, 1);
        settle(4);
        chk("drain_peak_queue", peak_exp_q.size(), 0);
        chk("drain_amp_queue", amp_exp_q.size(), 0);
        chk("final_amp", int'(amplitude), m_amp);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/amplitude_agc.md
AMPLITUDE_AGC -- requirements
Module: amplitude_agc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, sample and amplitude width (Q1.(DATA_WIDTH-1)).
REQ-002 SHALL have parameter WINDOW_LOG2, default 10, measurement window of 2^WINDOW_LOG2 valid samples.
REQ-003 SHALL have parameter TOL, default 256, lock tolerance band around target.
REQ-004 SHALL have parameter AMP_INIT, default 16384, amplitude value after reset.
REQ-005 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port enable  input  1  run AGC loop when high.
REQ-008 SHALL have port target  input  DATA_WIDTH  desired peak magnitude, non-negative.
REQ-009 SHALL have port step  input  DATA_WIDTH  amplitude increment/decrement per update, non-negative.
REQ-010 SHALL have port data_i_tdata  input  DATA_WIDTH signed  observed sample stream.
REQ-011 SHALL have port data_i_tvalid  input  1  sample qualifier; no backpressure.
REQ-012 SHALL have port amplitude  output  DATA_WIDTH signed  gain word driving the amplitude multiplier.
REQ-013 SHALL have port peak_tdata  output  DATA_WIDTH  window peak magnitude.
REQ-014 SHALL have port peak_tvalid  output  1  one-cycle pulse, peak_tdata valid.
REQ-015 SHALL have port locked  output  1  last update found peak within target +/- TOL.

Function
REQ-016 SHALL compute magnitude |x|; x = -2^(DATA_WIDTH-1) saturates to 2^(DATA_WIDTH-1)-1.
REQ-017 SHALL implement states IDLE, MEASURE, UPDATE.
REQ-018 IDLE: window counter and running peak held 0, amplitude held; enable=1 -> MEASURE next cycle.
REQ-019 MEASURE: each cycle with data_i_tvalid=1 increments counter and sets running peak = max(peak, |x|); tvalid=0 cycles change nothing.
REQ-020 On the valid sample with counter = 2^WINDOW_LOG2-1: peak_tdata <= max(peak, |x|), peak_tvalid=1 the next cycle, counter wraps to 0, running peak cleared, state -> UPDATE.
REQ-021 UPDATE (one cycle, coincident with peak_tvalid): if peak_tdata > target+TOL, amplitude -= step, saturating at 0; if peak_tdata < target-TOL (compare with target-TOL clamped at 0), amplitude += step, saturating at 2^(DATA_WIDTH-1)-1; else amplitude unchanged.
REQ-022 locked SHALL update in UPDATE only: 1 if within band, 0 otherwise.
REQ-023 target, step SHALL be sampled in the UPDATE cycle only.
REQ-024 Valid samples during UPDATE SHALL count as the first sample of the next window.
REQ-025 UPDATE -> MEASURE if enable=1, else IDLE.
REQ-026 enable=0 in MEASURE SHALL abort the window: no peak_tvalid, counter and peak cleared, IDLE next cycle; locked and amplitude retained.
REQ-027 Arithmetic for saturating add/subtract SHALL use DATA_WIDTH+1 bits; no wrap-around permitted.
REQ-028 amplitude latency: changes exactly 1 cycle after the last window sample's peak_tvalid edge (same clock edge peak_tvalid falls).

Reset
REQ-029 resetn=0 at a clock edge SHALL force: state IDLE, counter 0, running peak 0, peak_tdata 0, peak_tvalid 0, locked 0, amplitude AMP_INIT.
REQ-030 Reset mid-window SHALL discard the partial window; no peak_tvalid after release until a full window completes.

Configuration
REQ-031 Macro AMP_AGC_FREEZE_EN defined: adds input port freeze (1 bit); freeze=1 in UPDATE holds amplitude and locked unchanged, peak_tvalid/peak_tdata still produced.
REQ-032 AMP_AGC_FREEZE_EN undefined: no freeze port; every UPDATE applies REQ-021/022.

Verification (WINDOW_LOG2=2, TOL=256, AMP_INIT=16384)
REQ-033 Samples 100,-3000,2000,500 valid back-to-back, target=1000, step=1024 -> peak_tdata=3000 pulse, amplitude 16384->15360, locked=0.
REQ-034 Four samples of -32768, target=1000 -> peak_tdata=32767; repeated windows drive amplitude to 0 and hold at 0 (no wrap).
REQ-035 Four samples of 10, target=30000, step=8192 repeated -> amplitude 24576, 32767, 32767 (saturated); locked=0.
REQ-036 Samples peaking 1100, target=1000 -> amplitude unchanged, locked=1; gapped tvalid (1 of 3 cycles) gives same result.
REQ-037 Drop enable after 2 valid samples, reassert -> no peak_tvalid until 4 fresh valid samples; resetn pulse mid-window -> amplitude=16384, locked=0, outputs 0.
REQ-038 With AMP_AGC_FREEZE_EN, freeze=1, peak 3000, target 1000 -> peak_tvalid pulses, amplitude stays 16384.
